// File: rtl/array_arbiter_pkg.sv
// Shared types and helpers for the array port arbiter.
package array_arbiter_pkg;

   // Arbiter states: IDLE arbitrates, BUSY forwards the granted client.
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Width of an index able to address n items (at least one bit).
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Single-step modulo for values known to be below 2*n.
   function automatic int rr_wrap(input int v, input int n);
      return (v >= n) ? v - n : v;
   endfunction

endpackage

// File: rtl/array_arbiter_rr_select.sv
// Rotating priority encoder: first set request at or after ptr, cyclically.
module rr_select
   import array_arbiter_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int PW   = 1
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [PW-1:0]   idx_o,
   output logic            any_o
);

   logic [PW-1:0]   cand [NREQ];
   logic [NREQ-1:0] hit;

   // Candidate gi is the client gi positions after the pointer.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
         assign cand[gi] = PW'(rr_wrap(int'(ptr_i) + gi, NREQ));
         assign hit[gi]  = req_i[cand[gi]];
      end
   endgenerate

   // Lowest rotated position wins; scanning downwards leaves it last-assigned.
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (hit[k]) begin
            idx_o = cand[k];
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/array_arbiter.sv
// Round-robin arbiter sharing one array memory port between NREQ clients,
// with bounded locking for atomic read-modify-write sequences.
module array_arbiter
   import array_arbiter_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int INTN    = 8,
   parameter int ADDRN   = 8,
   parameter int MAXLOCK = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ-1:0]         req_we,
   input  logic [NREQ-1:0]         req_lock,
   input  logic [NREQ*ADDRN-1:0]   req_addr,
   input  logic [NREQ*INTN-1:0]    req_di,
   output logic [NREQ-1:0]         req_ready,
   output logic [INTN-1:0]         req_do,
   output logic                    arr_valid,
   output logic                    arr_we,
   output logic [ADDRN-1:0]        arr_addr,
   output logic [INTN-1:0]         arr_di,
   input  logic                    arr_ready,
   input  logic [INTN-1:0]         arr_do
);

   localparam int PW = idx_width(NREQ);
   localparam int LW = idx_width(MAXLOCK);
   localparam logic [LW-1:0] LOCK_LAST = LW'(MAXLOCK - 1);

   state_t        state_q, state_d;
   logic [PW-1:0] grant_q, grant_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [LW-1:0] lock_cnt_q, lock_cnt_d;
   logic          gap_q, gap_d;     // one-cycle grace already spent in a lock gap

   logic [ADDRN-1:0] addr_arr [NREQ];
   logic [INTN-1:0]  di_arr   [NREQ];
   logic [PW-1:0]    sel_idx;
   logic             sel_any;
   logic             busy;
   logic             g_valid;
   logic             hs;
   logic             do_release;
   logic [PW-1:0]    next_ptr;

   // Split the packed client buses into per-client words.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign addr_arr[gi] = req_addr[gi*ADDRN +: ADDRN];
         assign di_arr[gi]   = req_di[gi*INTN +: INTN];
      end
   endgenerate

   rr_select #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr_select (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .idx_o (sel_idx),
      .any_o (sel_any)
   );

   assign busy     = (state_q == ST_BUSY);
   assign g_valid  = req_valid[grant_q];
   assign next_ptr = PW'(rr_wrap(int'(grant_q) + 1, NREQ));

   // Forward the granted client to the array and return its handshake.
   always_comb begin
      arr_valid = busy & g_valid;
      arr_we    = busy & req_we[grant_q];
      arr_addr  = busy ? addr_arr[grant_q] : '0;
      arr_di    = busy ? di_arr[grant_q] : '0;
      hs        = arr_valid & arr_ready;
      req_ready = '0;
      if (hs) begin
         req_ready[grant_q] = 1'b1;
      end
      req_do = hs ? arr_do : '0;
   end

   // Grant, lock-burst and release decisions.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      ptr_d      = ptr_q;
      lock_cnt_d = lock_cnt_q;
      gap_d      = gap_q;
      do_release = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sel_any) begin
               state_d    = ST_BUSY;
               grant_d    = sel_idx;
               lock_cnt_d = '0;
               gap_d      = 1'b0;
            end
         end
         ST_BUSY: begin
            if (hs) begin
               if (req_lock[grant_q] && (lock_cnt_q < LOCK_LAST)) begin
                  lock_cnt_d = lock_cnt_q + 1'b1;
                  gap_d      = 1'b0;
               end else begin
                  do_release = 1'b1;
               end
            end else if (!g_valid) begin
               // A locked owner gets one idle cycle to present its next access.
               if ((lock_cnt_q != '0) && !gap_q) begin
                  gap_d = 1'b1;
               end else begin
                  do_release = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (do_release) begin
         state_d    = ST_IDLE;
         ptr_d      = next_ptr;
         lock_cnt_d = '0;
         gap_d      = 1'b0;
      end
   end

   // State registers; reset aborts any transaction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         ptr_q      <= '0;
         lock_cnt_q <= '0;
         gap_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         ptr_q      <= ptr_d;
         lock_cnt_q <= lock_cnt_d;
         gap_q      <= gap_d;
      end
   end

endmodule
